// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte-wide 8N1 UART transmitter fed by a 4-entry FIFO. Bytes are written
//   through a valid/ready handshake. The FSM (IDLE/START/DATA/STOP) pops one
//   byte per frame and shifts it out LSB first on a registered serial pin.
//   Back-to-back frames follow each other with no idle cycle between the
//   stop bit and the next start bit.
//
// Parameters
//   CLKDIV    clock cycles per UART bit, legal range 2..255 (8-bit divider)
//
// Ports
//   C         clock, all state updates on the rising edge
//   R         asynchronous active-high reset
//   wr_valid  a byte is offered on wr_data
//   wr_data   byte to transmit
//   wr_ready  FIFO can accept a byte (count < 4), from registered state only
//   tx        serial line, driven directly from a flop, idles high
//   busy      FSM is not IDLE
//   count     FIFO occupancy, 0..4
module uart_tx_fifo #(
    parameter int CLKDIV = 16
) (
    input  logic       C,
    input  logic       R,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       tx,
    output logic       busy,
    output logic [2:0] count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

    // Registered state
    state_t     state;
    logic [7:0] div;
    logic [2:0] bit_idx;
    logic [7:0] shift;
    logic [7:0] mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;

    // Next-state values
    state_t     state_nx;
    logic [7:0] div_nx;
    logic [2:0] bit_idx_nx;
    logic [7:0] shift_nx;
    logic       tx_nx;
    logic       pop;
    logic       push;
    logic       bit_end;

    assign wr_ready = (count < 3'd4);
    assign push     = wr_valid && wr_ready;
    assign bit_end  = (div == DIV_LAST);

    // ------------------------------------------------------------------
    // State register and FIFO storage
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the values from before the edge.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state   <= IDLE;
            div     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            tx      <= 1'b1;
            // NOTE: the FIFO array is reset too, so that every storage bit
            // maps onto a resettable flop rather than a plain memory.
            for (int i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state   <= state_nx;
            div     <= div_nx;
            bit_idx <= bit_idx_nx;
            shift   <= shift_nx;
            tx      <= tx_nx;

            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end

            // A simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nx   = state;
        div_nx     = div;
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        pop        = 1'b0;

        case (state)
            IDLE: begin
                div_nx = '0;
                if (count != 3'd0) begin
                    pop      = 1'b1;
                    shift_nx = mem[rd_ptr];
                    state_nx = START;
                end
            end

            START: begin
                if (bit_end) begin
                    div_nx     = '0;
                    bit_idx_nx = '0;
                    state_nx   = DATA;
                end else begin
                    div_nx = div + 8'd1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    div_nx   = '0;
                    shift_nx = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nx = STOP;
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end else begin
                    div_nx = div + 8'd1;
                end
            end

            STOP: begin
                if (bit_end) begin
                    div_nx = '0;
                    // Chain straight into the next start bit when a byte waits.
                    if (count != 3'd0) begin
                        pop      = 1'b1;
                        shift_nx = mem[rd_ptr];
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    div_nx = div + 8'd1;
                end
            end

            default: begin
                state_nx = IDLE;
                div_nx   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    // The serial pin is a flop, so its next value is derived from the
    // state being entered; tx then changes only on bit boundaries.
    always_comb begin
        tx_nx = 1'b1;
        busy  = (state != IDLE);

        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = shift_nx[0];
            default: tx_nx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo. Two instances are built, one with
//   CLKDIV=4 and one with CLKDIV=2; sel chooses which one the stimulus
//   drives and whose outputs are observed. Every tx value is recorded once
//   per cycle on the falling edge so whole frames can be compared against
//   hand-written bit patterns (written first-transmitted bit on the left:
//   start, d0..d7, stop).
module tb_uart_tx_fifo;

    logic       C        = 1'b0;
    logic       R        = 1'b0;
    logic       clk_en   = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data  = 8'h00;
    logic       sel      = 1'b0;

    logic       wv4, wv2;
    logic       rdy4, tx4, busy4;
    logic       rdy2, tx2, busy2;
    logic [2:0] cnt4, cnt2;

    logic       rdy, txm, bsy;
    logic [2:0] cnt;

    assign wv4 = wr_valid & ~sel;
    assign wv2 = wr_valid & sel;
    assign rdy = sel ? rdy2  : rdy4;
    assign txm = sel ? tx2   : tx4;
    assign bsy = sel ? busy2 : busy4;
    assign cnt = sel ? cnt2  : cnt4;

    uart_tx_fifo #(.CLKDIV(4)) u_div4 (
        .C        (C),
        .R        (R),
        .wr_valid (wv4),
        .wr_data  (wr_data),
        .wr_ready (rdy4),
        .tx       (tx4),
        .busy     (busy4),
        .count    (cnt4)
    );

    uart_tx_fifo #(.CLKDIV(2)) u_div2 (
        .C        (C),
        .R        (R),
        .wr_valid (wv2),
        .wr_data  (wr_data),
        .wr_ready (rdy2),
        .tx       (tx2),
        .busy     (busy2),
        .count    (cnt2)
    );

    always begin
        #5;
        if (clk_en) C = ~C;
    end

    // Per-cycle record of the observed tx pin.
    logic rec [4096];
    int   cyc = 0;

    always @(negedge C) begin
        if (cyc < 4096) rec[cyc] = txm;
        cyc = cyc + 1;
    end

    int total = 0;
    int bad   = 0;

    logic [9:0] full_pat [6] = '{
        10'b0100000001,   // 0x01
        10'b0010000001,   // 0x02
        10'b0110000001,   // 0x03
        10'b0001000001,   // 0x04
        10'b0101000001,   // 0x05
        10'b0011000001    // 0x06
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next falling edge: outputs are stable there
    // and inputs changed there are settled long before the rising edge.
    task automatic step();
        @(negedge C);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int limit, output int idx);
        int n = 0;
        while (bsy && n < limit) begin
            step();
            n++;
        end
        check({tag, "_idle"}, 32'(bsy), 0);
        idx = cyc - 1;
    endtask

    task automatic verify_frame(input string tag, input int start, input int cdiv,
                                input logic [9:0] pat);
        logic [9:0] obs;
        int         mism;
        int         idx;
        obs  = '0;
        mism = 0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < cdiv; c++) begin
                idx = start + b * cdiv + c;
                if (idx < 0 || idx >= 4096) begin
                    mism++;
                end else begin
                    if (c == 0) obs[9 - b] = rec[idx];
                    if (rec[idx] !== pat[9 - b]) mism++;
                end
            end
        end
        check(tag, 32'(obs), 32'(pat));
        check({tag, "_hold"}, mism, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t0;
        int         tend;
        int         n;
        int         stuck;
        logic [4:0] pat5;

        // ---------------- reset with no clock ----------------
        #1 R = 1'b1;
        #2;
        check("rst_tx",     32'(tx4),   1);
        check("rst_busy",   32'(busy4), 0);
        check("rst_count",  32'(cnt4),  0);
        check("rst_ready",  32'(rdy4),  1);
        check("rst_tx_d2",  32'(tx2),   1);
        check("rst_cnt_d2", 32'(cnt2),  0);

        clk_en = 1'b1;
        repeat (3) step();
        R = 1'b0;
        step();

        // ---------------- single byte 0xA5, CLKDIV=4 ----------------
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        step();
        check("a5_push_count", 32'(cnt), 1);
        check("a5_push_busy",  32'(bsy), 0);
        check("a5_push_tx",    32'(txm), 1);
        wr_valid = 1'b0;
        step();
        t0 = cyc - 1;
        check("a5_lat_tx",    32'(txm), 0);
        check("a5_lat_count", 32'(cnt), 0);
        check("a5_lat_busy",  32'(bsy), 1);
        wait_idle("a5", 100, tend);
        check("a5_len",      tend - t0, 40);
        check("a5_tx_after", 32'(txm), 1);
        verify_frame("a5_frame", t0, 4, 10'b0101001011);

        // ---------------- back-to-back 0x00, 0xFF ----------------
        wr_valid = 1'b1;
        wr_data  = 8'h00;
        step();
        wr_data = 8'hFF;
        step();
        wr_valid = 1'b0;
        t0 = cyc - 1;
        check("b2b_count", 32'(cnt), 1);
        check("b2b_tx",    32'(txm), 0);
        wait_idle("b2b", 200, tend);
        check("b2b_len", tend - t0, 80);
        verify_frame("b2b_f1", t0,      4, 10'b0000000001);
        verify_frame("b2b_f2", t0 + 40, 4, 10'b0111111111);

        // ---------------- full FIFO, 0x01..0x06 ----------------
        wr_valid = 1'b1;
        wr_data  = 8'h01;
        step();
        check("full_c1", 32'(cnt), 1);
        wr_data = 8'h02;
        step();
        t0 = cyc - 1;
        check("full_c2", 32'(cnt), 1);
        wr_data = 8'h03;
        step();
        check("full_c3", 32'(cnt), 2);
        wr_data = 8'h04;
        step();
        check("full_c4", 32'(cnt), 3);
        wr_data = 8'h05;
        step();
        check("full_c5",     32'(cnt), 4);
        check("full_ready0", 32'(rdy), 0);
        wr_data = 8'h06;
        n     = 0;
        stuck = 0;
        while (!rdy && n < 100) begin
            step();
            n++;
            if (!rdy && cnt !== 3'd4) stuck++;
        end
        check("full_wait_count", stuck, 0);
        check("full_pop_at",     (cyc - 1) - t0, 40);
        check("full_pop_count",  32'(cnt), 3);
        step();
        wr_valid = 1'b0;
        check("full_06_count", 32'(cnt), 4);
        check("full_06_ready", 32'(rdy), 0);
        wait_idle("full", 400, tend);
        check("full_len", tend - t0, 240);
        for (int i = 0; i < 6; i++) begin
            verify_frame($sformatf("full_f%0d", i + 1), t0 + 40 * i, 4, full_pat[i]);
        end

        // ---------------- mid-frame reset during data bit 3 of 0x3C ----------------
        wr_valid = 1'b1;
        wr_data  = 8'h3C;
        step();
        wr_data = 8'h11;
        step();
        t0      = cyc - 1;
        wr_data = 8'h22;
        step();
        wr_valid = 1'b0;
        check("mrst_queued", 32'(cnt), 2);
        repeat (17) step();
        check("mrst_bit3_tx",   32'(txm), 1);
        check("mrst_bit3_busy", 32'(bsy), 1);
        pat5 = 5'b00011;   // start, d0=0, d1=0, d2=1, d3=1
        n = 0;
        for (int i = 0; i < 19; i++) begin
            if (rec[t0 + i] !== pat5[4 - i / 4]) n++;
        end
        check("mrst_prefix", n, 0);
        R = 1'b1;
        #1;
        check("mrst_tx",    32'(txm), 1);
        check("mrst_count", 32'(cnt), 0);
        check("mrst_busy",  32'(bsy), 0);
        check("mrst_ready", 32'(rdy), 1);
        repeat (2) step();

        // Release and push on the very first edge with R low.
        R        = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 8'h81;
        step();
        wr_valid = 1'b0;
        check("rel_count", 32'(cnt), 1);
        step();
        t0 = cyc - 1;
        check("rel_tx", 32'(txm), 0);
        wait_idle("rel", 100, tend);
        check("rel_len", tend - t0, 40);
        verify_frame("rel_frame", t0, 4, 10'b0100000011);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (txm !== 1'b1 || bsy !== 1'b0 || cnt !== 3'd0) n++;
        end
        check("mrst_quiet", n, 0);

        // ---------------- CLKDIV=2, 0x55 ----------------
        sel      = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h55;
        step();
        wr_valid = 1'b0;
        check("d2_count", 32'(cnt), 1);
        step();
        t0 = cyc - 1;
        check("d2_tx", 32'(txm), 0);
        wait_idle("d2", 100, tend);
        check("d2_len", tend - t0, 20);
        verify_frame("d2_frame", t0, 2, 10'b0101010101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
